// File: rtl/pipe_pkg.sv
// Shared constants and helpers for the elastic pipeline register chain.
package pipe_pkg;

  // A control field with every bit at this value is a NOP.
  localparam logic CTRL_NOP = 1'b0;

  function automatic int occ_width(input int stages);
    return $clog2(stages + 2);
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipeline slot: valid/data/ctrl register with load and kill.
module pipe_slot #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              kill,
  input  logic              next_v,
  input  logic [DATA_W-1:0] next_d,
  input  logic [CTRL_W-1:0] next_c,
  output logic              v,
  output logic [DATA_W-1:0] d,
  output logic [CTRL_W-1:0] c
);

  // Kill overrides load so an entry offered into a flushed slot is dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v <= 1'b0;
      d <= '0;
      c <= '0;
    end else begin
      if (kill)      v <= 1'b0;
      else if (load) v <= next_v;
      if (load) begin
        d <= next_d;
        c <= next_c;
      end
    end
  end

endmodule

// File: rtl/elastic_pipe.sv
// Handshaked pipeline register chain with flush, bubble injection,
// optional input skid buffer and occupancy counter.
module elastic_pipe
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 11,
  parameter int STAGES = 3,
  parameter int SKID   = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_W-1:0]             in_data,
  input  logic [CTRL_W-1:0]             in_ctrl,
  input  logic [STAGES-1:0]             flush,
  input  logic                          bubble,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_W-1:0]             out_data,
  output logic [CTRL_W-1:0]             out_ctrl,
  output logic [STAGES-1:0]             stage_valid,
  output logic [occ_width(STAGES)-1:0]  occupancy
);

  localparam int OCC_W = occ_width(STAGES);

  logic [STAGES-1:0] v;
  logic [STAGES-1:0] l;
  logic [STAGES-1:0] src_v;
  logic [STAGES-1:0] v_nxt;
  logic [STAGES:0]   adv;
  logic [DATA_W-1:0] d     [STAGES];
  logic [CTRL_W-1:0] c     [STAGES];
  logic [DATA_W-1:0] src_d [STAGES];
  logic [CTRL_W-1:0] src_c [STAGES];

  logic              skid_v;
  logic              skid_v_nxt;
  logic [DATA_W-1:0] skid_d;
  logic [CTRL_W-1:0] skid_c;
  logic              fire;
  logic              skid_load;
  logic [OCC_W-1:0]  occ_nxt;

  assign l = v & ~flush;

  // A slot may take new content when it holds nothing live or drains this edge.
  always_comb begin
    adv[STAGES] = out_ready;
    for (int i = STAGES - 1; i >= 0; i--) begin
      adv[i] = ~l[i] | adv[i+1];
    end
  end

  assign in_ready  = (SKID != 0) ? ~skid_v : (adv[0] & ~bubble);
  assign fire      = in_valid & in_ready;
  assign skid_load = (SKID != 0) && fire && (!adv[0] || bubble);

  always_comb begin
    src_v[0] = in_valid;
    src_d[0] = in_data;
    src_c[0] = in_ctrl;
    if (skid_v) begin
      src_v[0] = 1'b1;
      src_d[0] = skid_d;
      src_c[0] = skid_c;
    end else if (bubble) begin
      src_v[0] = 1'b1;
      src_d[0] = '0;
      src_c[0] = {CTRL_W{CTRL_NOP}};
    end
    for (int i = 1; i < STAGES; i++) begin
      src_v[i] = l[i-1];
      src_d[i] = d[i-1];
      src_c[i] = c[i-1];
    end
  end

  genvar g;
  generate
    for (g = 0; g < STAGES; g++) begin : g_slot
      pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_slot (
        .clk    (clk),
        .rst    (rst),
        .load   (adv[g]),
        .kill   (flush[g]),
        .next_v (src_v[g]),
        .next_d (src_d[g]),
        .next_c (src_c[g]),
        .v      (v[g]),
        .d      (d[g]),
        .c      (c[g])
      );
    end
  endgenerate

  always_comb begin
    skid_v_nxt = skid_v;
    if (skid_v && adv[0]) skid_v_nxt = 1'b0;
    if (skid_load)        skid_v_nxt = 1'b1;
    if (flush[0])         skid_v_nxt = 1'b0;
  end

  // Mirror of the slot update rule, so the counter tracks the post-edge state.
  always_comb begin
    occ_nxt = OCC_W'(skid_v_nxt);
    for (int i = 0; i < STAGES; i++) begin
      v_nxt[i] = flush[i] ? 1'b0 : (adv[i] ? src_v[i] : v[i]);
      occ_nxt  = occ_nxt + OCC_W'(v_nxt[i]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      skid_v    <= 1'b0;
      skid_d    <= '0;
      skid_c    <= '0;
      occupancy <= '0;
    end else begin
      skid_v    <= skid_v_nxt;
      occupancy <= occ_nxt;
      if (skid_load) begin
        skid_d <= in_data;
        skid_c <= in_ctrl;
      end
    end
  end

  assign out_valid   = l[STAGES-1];
  assign out_data    = d[STAGES-1];
  assign out_ctrl    = c[STAGES-1];
  assign stage_valid = v;

endmodule

// File: tb/tb_elastic_pipe.sv
// Directed bench for elastic_pipe: one instance without skid, one with.
module tb_elastic_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  logic        in_valid, in_ready, bubble, out_valid, out_ready;
  logic [31:0] in_data, out_data;
  logic [10:0] in_ctrl, out_ctrl;
  logic [2:0]  flush, stage_valid, occupancy;

  logic        s_in_valid, s_in_ready, s_bubble, s_out_valid, s_out_ready;
  logic [31:0] s_in_data, s_out_data;
  logic [10:0] s_in_ctrl, s_out_ctrl;
  logic [2:0]  s_flush, s_stage_valid, s_occupancy;

  always #5 clk = ~clk;

  elastic_pipe #(.DATA_W(32), .CTRL_W(11), .STAGES(3), .SKID(0)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush), .bubble(bubble),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ctrl(out_ctrl), .stage_valid(stage_valid), .occupancy(occupancy));

  elastic_pipe #(.DATA_W(32), .CTRL_W(11), .STAGES(3), .SKID(1)) u_skid (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_data(s_in_data), .in_ctrl(s_in_ctrl), .flush(s_flush), .bubble(s_bubble),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
    .out_ctrl(s_out_ctrl), .stage_valid(s_stage_valid), .occupancy(s_occupancy));

  function automatic logic [10:0] cf(input logic [31:0] x);
    return x[10:0] | 11'h400;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic test_reset;
    in_valid = 0; in_data = 0; in_ctrl = 0; flush = 0; bubble = 0; out_ready = 0;
    s_in_valid = 0; s_in_data = 0; s_in_ctrl = 0; s_flush = 0; s_bubble = 0; s_out_ready = 0;
    #3 rst = 0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got %0b want 0", out_valid); end
    n_cmp++; if (out_data !== 32'd0) begin n_err++; $display("FAIL rst_out_data got %0h want 0", out_data); end
    n_cmp++; if (out_ctrl !== 11'd0) begin n_err++; $display("FAIL rst_out_ctrl got %0h want 0", out_ctrl); end
    n_cmp++; if (stage_valid !== 3'b000) begin n_err++; $display("FAIL rst_stage_valid got %b want 000", stage_valid); end
    n_cmp++; if (occupancy !== 3'd0) begin n_err++; $display("FAIL rst_occupancy got %0d want 0", occupancy); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready got %0b want 1", in_ready); end
    n_cmp++; if (s_occupancy !== 3'd0) begin n_err++; $display("FAIL rst_skid_occupancy got %0d want 0", s_occupancy); end
    bubble = 1; s_bubble = 1;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_bubble_in_ready got %0b want 0", in_ready); end
    n_cmp++; if (s_in_ready !== 1'b1) begin n_err++; $display("FAIL rst_skid_bubble_in_ready got %0b want 1", s_in_ready); end
    bubble = 0; s_bubble = 0;
    @(negedge clk);
    rst = 1;
    tick;
  endtask

  task automatic test_stream;
    int lo, hi, exp_occ, peak;
    logic exp_v;
    peak = 0;
    out_ready = 1;
    for (int j = 1; j <= 11; j++) begin
      if (j <= 8) begin in_valid = 1; in_data = j; in_ctrl = cf(j); end
      else in_valid = 0;
      settle;
      if (j <= 8) begin
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL stream_in_ready cyc %0d got %0b want 1", j, in_ready); end
      end
      tick;
      exp_v = (j >= 3) && (j <= 10);
      n_cmp++; if (out_valid !== exp_v) begin n_err++; $display("FAIL stream_out_valid cyc %0d got %0b want %0b", j, out_valid, exp_v); end
      if (exp_v) begin
        n_cmp++; if (out_data !== 32'(j - 2)) begin n_err++; $display("FAIL stream_out_data cyc %0d got %0d want %0d", j, out_data, j - 2); end
        n_cmp++; if (out_ctrl !== cf(32'(j - 2))) begin n_err++; $display("FAIL stream_out_ctrl cyc %0d got %0h want %0h", j, out_ctrl, cf(32'(j - 2))); end
      end
      lo = (j - 2 < 1) ? 1 : j - 2;
      hi = (j > 8) ? 8 : j;
      exp_occ = (hi >= lo) ? hi - lo + 1 : 0;
      n_cmp++; if (occupancy !== 3'(exp_occ)) begin n_err++; $display("FAIL stream_occupancy cyc %0d got %0d want %0d", j, occupancy, exp_occ); end
      if (int'(occupancy) > peak) peak = int'(occupancy);
    end
    n_cmp++; if (peak !== 3) begin n_err++; $display("FAIL stream_peak_occ got %0d want 3", peak); end
  endtask

  task automatic test_backpressure;
    int sent, got;
    logic acc, take;
    sent = 0; got = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      out_ready = (cyc >= 5);
      in_valid  = (sent < 8);
      in_data   = 32'(21 + sent);
      in_ctrl   = cf(32'(21 + sent));
      settle;
      if (cyc < 5) begin
        n_cmp++; if (in_ready !== (cyc < 3)) begin n_err++; $display("FAIL bp_in_ready cyc %0d got %0b want %0b", cyc, in_ready, cyc < 3); end
      end
      acc  = in_valid && in_ready;
      take = out_valid && out_ready;
      if (take) begin
        n_cmp++; if (out_data !== 32'(21 + got)) begin n_err++; $display("FAIL bp_order got %0d want %0d", out_data, 21 + got); end
        got++;
      end
      tick;
      if (acc) sent++;
      if (cyc >= 2 && cyc < 5) begin
        n_cmp++; if (occupancy !== 3'd3) begin n_err++; $display("FAIL bp_occ_hold cyc %0d got %0d want 3", cyc, occupancy); end
      end
    end
    in_valid = 0;
    n_cmp++; if (got !== 8) begin n_err++; $display("FAIL bp_count got %0d want 8", got); end
    n_cmp++; if (occupancy !== 3'd0) begin n_err++; $display("FAIL bp_drained got %0d want 0", occupancy); end
  endtask

  task automatic test_flush;
    logic [31:0] abc [3];
    abc[0] = 32'hAA; abc[1] = 32'hBB; abc[2] = 32'hCC;
    out_ready = 0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1; in_data = abc[k]; in_ctrl = cf(abc[k]);
      tick;
    end
    n_cmp++; if (stage_valid !== 3'b111) begin n_err++; $display("FAIL flush_full got %b want 111", stage_valid); end
    in_valid = 0; flush = 3'b011;
    settle;
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'hAA) begin n_err++; $display("FAIL flush_out_live got %0b/%0h want 1/aa", out_valid, out_data); end
    tick;
    flush = 3'b000;
    n_cmp++; if (stage_valid !== 3'b100) begin n_err++; $display("FAIL flush_holes got %b want 100", stage_valid); end
    n_cmp++; if (occupancy !== 3'd1) begin n_err++; $display("FAIL flush_occ got %0d want 1", occupancy); end
    in_valid = 1; in_data = 32'hDD; in_ctrl = cf(32'hDD);
    tick;
    in_valid = 0;
    n_cmp++; if (stage_valid !== 3'b101) begin n_err++; $display("FAIL flush_refill0 got %b want 101", stage_valid); end
    tick;
    n_cmp++; if (stage_valid !== 3'b110) begin n_err++; $display("FAIL flush_compress got %b want 110", stage_valid); end
    in_valid = 1; in_data = 32'hEE; in_ctrl = cf(32'hEE); flush = 3'b001;
    tick;
    in_valid = 0; flush = 3'b000;
    n_cmp++; if (stage_valid !== 3'b110) begin n_err++; $display("FAIL flush_drop_incoming got %b want 110", stage_valid); end
    n_cmp++; if (occupancy !== 3'd2) begin n_err++; $display("FAIL flush_occ2 got %0d want 2", occupancy); end
    out_ready = 1;
    settle;
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'hAA) begin n_err++; $display("FAIL flush_emit_a got %0b/%0h want 1/aa", out_valid, out_data); end
    tick;
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'hDD) begin n_err++; $display("FAIL flush_emit_d got %0b/%0h want 1/dd", out_valid, out_data); end
    tick;
    n_cmp++; if (out_valid !== 1'b0 || occupancy !== 3'd0) begin n_err++; $display("FAIL flush_empty got %0b/%0d want 0/0", out_valid, occupancy); end
  endtask

  task automatic test_bubble;
    out_ready = 1;
    bubble = 1; in_valid = 1; in_data = 32'h1234; in_ctrl = cf(32'h1234);
    settle;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bubble_in_ready got %0b want 0", in_ready); end
    tick;
    bubble = 0;
    settle;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bubble_after_ready got %0b want 1", in_ready); end
    tick;
    in_valid = 0;
    tick;
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'd0 || out_ctrl !== 11'd0) begin n_err++; $display("FAIL bubble_nop got %0b/%0h/%0h want 1/0/0", out_valid, out_data, out_ctrl); end
    tick;
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'h1234 || out_ctrl !== cf(32'h1234)) begin n_err++; $display("FAIL bubble_x got %0b/%0h/%0h want 1/1234/%0h", out_valid, out_data, out_ctrl, cf(32'h1234)); end
    tick;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bubble_end got %0b want 0", out_valid); end
  endtask

  task automatic test_skid;
    s_out_ready = 1; s_in_valid = 1;
    for (int k = 0; k < 3; k++) begin
      s_in_data = 32'(41 + k); s_in_ctrl = cf(32'(41 + k));
      tick;
    end
    s_out_ready = 0; s_in_data = 32'd44; s_in_ctrl = cf(32'd44);
    settle;
    n_cmp++; if (s_in_ready !== 1'b1) begin n_err++; $display("FAIL skid_ready_pre got %0b want 1", s_in_ready); end
    tick;
    n_cmp++; if (s_in_ready !== 1'b0) begin n_err++; $display("FAIL skid_ready_low got %0b want 0", s_in_ready); end
    n_cmp++; if (s_occupancy !== 3'd4) begin n_err++; $display("FAIL skid_occ4 got %0d want 4", s_occupancy); end
    n_cmp++; if (s_out_valid !== 1'b1 || s_out_data !== 32'd41) begin n_err++; $display("FAIL skid_head got %0b/%0d want 1/41", s_out_valid, s_out_data); end
    s_in_valid = 0; s_out_ready = 1;
    for (int k = 0; k < 3; k++) begin
      tick;
      n_cmp++; if (s_out_valid !== 1'b1 || s_out_data !== 32'(42 + k)) begin n_err++; $display("FAIL skid_drain got %0b/%0d want 1/%0d", s_out_valid, s_out_data, 42 + k); end
      if (k == 0) begin
        n_cmp++; if (s_occupancy !== 3'd3 || s_in_ready !== 1'b1) begin n_err++; $display("FAIL skid_unload got %0d/%0b want 3/1", s_occupancy, s_in_ready); end
      end
    end
    tick;
    n_cmp++; if (s_out_valid !== 1'b0 || s_occupancy !== 3'd0) begin n_err++; $display("FAIL skid_empty got %0b/%0d want 0/0", s_out_valid, s_occupancy); end
    s_in_valid = 1;
    for (int k = 0; k < 3; k++) begin
      s_in_data = 32'(51 + k); s_in_ctrl = cf(32'(51 + k));
      tick;
    end
    s_out_ready = 0; s_in_data = 32'd54; s_in_ctrl = cf(32'd54);
    tick;
    n_cmp++; if (s_occupancy !== 3'd4 || s_in_ready !== 1'b0) begin n_err++; $display("FAIL skid_refill got %0d/%0b want 4/0", s_occupancy, s_in_ready); end
    s_in_valid = 0; s_flush = 3'b001;
    tick;
    s_flush = 3'b000;
    n_cmp++; if (s_occupancy !== 3'd2 || s_in_ready !== 1'b1) begin n_err++; $display("FAIL skid_flush got %0d/%0b want 2/1", s_occupancy, s_in_ready); end
    n_cmp++; if (s_stage_valid !== 3'b110) begin n_err++; $display("FAIL skid_flush_sv got %b want 110", s_stage_valid); end
    s_out_ready = 1;
    settle;
    n_cmp++; if (s_out_valid !== 1'b1 || s_out_data !== 32'd51) begin n_err++; $display("FAIL skid_post_a got %0b/%0d want 1/51", s_out_valid, s_out_data); end
    tick;
    n_cmp++; if (s_out_valid !== 1'b1 || s_out_data !== 32'd52) begin n_err++; $display("FAIL skid_post_b got %0b/%0d want 1/52", s_out_valid, s_out_data); end
    tick;
    n_cmp++; if (s_out_valid !== 1'b0 || s_occupancy !== 3'd0) begin n_err++; $display("FAIL skid_post_empty got %0b/%0d want 0/0", s_out_valid, s_occupancy); end
  endtask

  task automatic test_reset_mid;
    out_ready = 1; in_valid = 1;
    for (int k = 0; k < 4; k++) begin
      in_data = 32'(61 + k); in_ctrl = cf(32'(61 + k));
      tick;
    end
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'd62) begin n_err++; $display("FAIL rmid_pre got %0b/%0d want 1/62", out_valid, out_data); end
    #2 rst = 0;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || out_data !== 32'd0 || out_ctrl !== 11'd0) begin n_err++; $display("FAIL rmid_out got %0b/%0h/%0h want 0/0/0", out_valid, out_data, out_ctrl); end
    n_cmp++; if (stage_valid !== 3'b000 || occupancy !== 3'd0) begin n_err++; $display("FAIL rmid_state got %b/%0d want 000/0", stage_valid, occupancy); end
    in_valid = 0;
    #2 rst = 1;
    for (int k = 0; k < 4; k++) begin
      tick;
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rmid_idle cyc %0d got %0b want 0", k, out_valid); end
    end
    in_valid = 1; in_data = 32'd70; in_ctrl = cf(32'd70);
    tick;
    in_valid = 0;
    tick;
    tick;
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'd70) begin n_err++; $display("FAIL rmid_new got %0b/%0d want 1/70", out_valid, out_data); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_bubble();
    test_skid();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/elastic_pipe.md
# elastic_pipe

Parametrised, handshaked pipeline register chain that generalises the fixed IF/ID, ID/EX, EX/MEM and MEM/WB stage registers. It carries a data field and a control field through `STAGES` slots with valid/ready flow control, per-stage flush, NOP bubble injection, an optional input skid buffer and an occupancy counter. Datapaths instantiate it between a producer stage (fetch/decode) and a consumer stage (execute/memory), and the hazard unit drives it.

## Interface
- `DATA_W`, 32: width of the data field (operands, PC+4, immediates).
- `CTRL_W`, 11: width of the control field; all-zero encodes NOP.
- `STAGES`, 3: number of register slots, ≥1.
- `SKID`, 0: 1 adds a one-entry input skid buffer and makes `in_ready` registered.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  producer offers an entry.
- `in_ready`  out  1  block accepts the entry this cycle.
- `in_data`  in  DATA_W  data field.
- `in_ctrl`  in  CTRL_W  control field.
- `flush`  in  STAGES  bit i kills the content of slot i.
- `bubble`  in  1  inject a NOP into slot 0 instead of consuming input.
- `out_valid`  out  1  last slot holds a live entry.
- `out_ready`  in  1  consumer takes the entry.
- `out_data`  out  DATA_W  last slot data.
- `out_ctrl`  out  CTRL_W  last slot control.
- `stage_valid`  out  STAGES  live bit per slot, for hazard/forwarding logic.
- `occupancy`  out  $clog2(STAGES+2)  live slots plus skid entry.

## Operation
- Each slot i holds `v[i]`, `d[i]`, `c[i]`. Live: `l[i] = v[i] & ~flush[i]`.
- Advance: `adv[STAGES] = out_ready`; `adv[i] = ~l[i] | adv[i+1]`. Slot i loads from slot i-1, or from input/skid/NOP when i=0, when `adv[i]` is true. It loads the upstream live bit, so killed entries become holes.
- `flush[i]` is absolute: after the edge, `v[i]=0`, whatever was offered into slot i. Killed content never reaches slot i+1.
- `out_valid = l[STAGES-1]`; `out_data`/`out_ctrl` come straight from the last slot. Transfer happens when `out_valid & out_ready`.
- Slot 0 source priority: skid entry (if SKID and skid valid), then NOP (if `bubble`), then the input.
- The NOP entry sets `v=1`, `c=0` and `d=0`. A bubble never consumes input.
- SKID=0: `in_ready = adv[0] & ~bubble` (combinational).
- SKID=1: `in_ready = ~skid_v` (registered).
  - A firing input goes to slot 0 when the skid is empty, `adv[0]` is true and `bubble` is low.
  - Otherwise it is written into the skid.
  - `flush[0]` also clears the skid.
- `occupancy` is a registered count of `v[]` plus `skid_v`, updated each edge to the post-edge state.
- `stage_valid[i] = v[i]` (registered; not masked by flush).

## Timing
- Reset (asynchronous assert, synchronous release): all `v`, `d`, `c`, skid and `occupancy` go to 0.
  - `out_valid=0`, `out_data=0`, `out_ctrl=0`, `stage_valid=0`.
  - `in_ready=1`, or 0 if `bubble` is high with SKID=0.
- Latency: an entry accepted at edge k appears on `out_*` after edge k+STAGES-1, or one edge later if it went through the skid. Throughput is 1 entry/cycle with `out_ready` held high.
- Stall: `out_ready=0` freezes full slots. Holes upstream still fill, so compression happens.
- Flush and stall together: flush wins and the slot empties.
- Flush and advance into the same slot together: the incoming entry is dropped.
- `bubble` with `adv[0]=0`: nothing happens, and the NOP is not remembered.
- A reset asserted mid-transfer discards every entry. No handshake completes on that edge.

## Structure
- Package `pipe_pkg` holds `CTRL_NOP` (all-zero control) and the `occupancy` width function.
- Sub-module `pipe_slot`: one valid/data/ctrl register with load and kill inputs, instantiated STAGES times in a generate loop. The skid buffer and counter live in the top level.

## Test plan
- Streaming, STAGES=3, SKID=0, `out_ready=1`: send data 1..8 back-to-back → outputs 1..8 on consecutive cycles, the first 3 cycles after acceptance, `occupancy` peaking at 3.
- Back-pressure: `out_ready=0` for 5 cycles while streaming → `in_ready` falls once 3 entries are held. Nothing is lost or duplicated, and order is preserved after release.
- Flush: pulse `flush=3'b011` while slots hold A, B, C (slot 0 = C) → only A emerges, and `stage_valid` shows the holes refilling.
- Bubble: hold `bubble=1` for one cycle while `in_valid=1` with data X → one entry with `ctrl=0`, `data=0` emerges, then X. With SKID=0, `in_ready` was 0 during the bubble.
- SKID=1: drop `out_ready` with a full pipe while streaming → one extra entry is captured in the skid, `in_ready` goes low the next cycle, and `occupancy` reaches 4. `flush[0]` then clears the skid.
- Reset mid-stream: assert `rst=0` asynchronously between edges → all outputs reach their reset values immediately, with no output transfer after release until new input arrives.
